// File: rtl/mccu_pkg.sv
// Shared encodings for the multicycle control unit: states, opcode/func fields,
// ALU operation codes and the decode/control payload structs.
package mccu_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned FN_W   = 6;
   localparam int unsigned ALUC_W = 4;
   localparam int unsigned ST_W   = 3;

   typedef enum logic [ST_W-1:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FN_W-1:0] FN_SLL = 6'h00;
   localparam logic [FN_W-1:0] FN_SRL = 6'h02;
   localparam logic [FN_W-1:0] FN_SRA = 6'h03;
   localparam logic [FN_W-1:0] FN_JR  = 6'h08;
   localparam logic [FN_W-1:0] FN_ADD = 6'h20;
   localparam logic [FN_W-1:0] FN_SUB = 6'h22;
   localparam logic [FN_W-1:0] FN_AND = 6'h24;
   localparam logic [FN_W-1:0] FN_OR  = 6'h25;
   localparam logic [FN_W-1:0] FN_XOR = 6'h26;

   localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
   localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
   localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
   localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
   localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
   localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
   localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
   localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
   localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

   // Instruction-class flags; rtype covers R-type ALU ops including shifts, not jr
   typedef struct packed {
      logic              legal;
      logic              rtype;
      logic              shift;
      logic              jr;
      logic              j;
      logic              jal;
      logic              beq;
      logic              bne;
      logic              lw;
      logic              sw;
      logic              itype;
      logic              sext;
      logic [ALUC_W-1:0] aluc;
   } dec_t;

   typedef struct packed {
      logic              wpc;
      logic              wir;
      logic              wmem;
      logic              wreg;
      logic              iord;
      logic              regrt;
      logic              m2reg;
      logic              shift;
      logic              alusrca;
      logic              jal;
      logic              sext;
      logic [1:0]        alusrcb;
      logic [1:0]        pcsource;
      logic [ALUC_W-1:0] aluc;
      logic              illegal;
   } ctrl_t;

endpackage

// File: rtl/mccu_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mccu_if;
   import mccu_pkg::*;

   logic [OP_W-1:0]   op;
   logic [FN_W-1:0]   func;
   logic              z;
   logic              mem_rdy;

   logic              wpc;
   logic              wir;
   logic              wmem;
   logic              wreg;
   logic              iord;
   logic              regrt;
   logic              m2reg;
   logic              shift;
   logic              alusrca;
   logic              jal;
   logic              sext;
   logic [1:0]        alusrcb;
   logic [1:0]        pcsource;
   logic [ALUC_W-1:0] aluc;
   logic [ST_W-1:0]   state;
   logic              illegal;

   modport master (
      input  op, func, z, mem_rdy,
      output wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
             alusrcb, pcsource, aluc, state, illegal
   );

   modport slave (
      output op, func, z, mem_rdy,
      input  wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
             alusrcb, pcsource, aluc, state, illegal
   );
endinterface

// File: rtl/mccu_decode.sv
// Combinational op/func decoder producing instruction-class flags and the EXE ALU code.
module mccu_decode
   import mccu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [FN_W-1:0] func,
   output dec_t            dec
);

   always_comb begin
      dec      = '0;
      dec.aluc = ALUC_ADD;
      case (op)
         OP_RTYPE: begin
            dec.legal = 1'b1;
            dec.rtype = 1'b1;
            case (func)
               FN_ADD: dec.aluc = ALUC_ADD;
               FN_SUB: dec.aluc = ALUC_SUB;
               FN_AND: dec.aluc = ALUC_AND;
               FN_OR:  dec.aluc = ALUC_OR;
               FN_XOR: dec.aluc = ALUC_XOR;
               FN_SLL: begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; end
               FN_SRL: begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; end
               FN_SRA: begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; end
               FN_JR:  begin dec.jr = 1'b1; dec.rtype = 1'b0; end
               default: begin dec.legal = 1'b0; dec.rtype = 1'b0; end
            endcase
         end
         OP_J:    begin dec.legal = 1'b1; dec.j   = 1'b1; end
         OP_JAL:  begin dec.legal = 1'b1; dec.jal = 1'b1; end
         OP_BEQ:  begin dec.legal = 1'b1; dec.beq = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_SUB; end
         OP_BNE:  begin dec.legal = 1'b1; dec.bne = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_SUB; end
         OP_ADDI: begin dec.legal = 1'b1; dec.itype = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_ADD; end
         OP_ANDI: begin dec.legal = 1'b1; dec.itype = 1'b1; dec.aluc = ALUC_AND; end
         OP_ORI:  begin dec.legal = 1'b1; dec.itype = 1'b1; dec.aluc = ALUC_OR;  end
         OP_XORI: begin dec.legal = 1'b1; dec.itype = 1'b1; dec.aluc = ALUC_XOR; end
         OP_LUI:  begin dec.legal = 1'b1; dec.itype = 1'b1; dec.aluc = ALUC_LUI; end
         OP_LW:   begin dec.legal = 1'b1; dec.lw = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_ADD; end
         OP_SW:   begin dec.legal = 1'b1; dec.sw = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_ADD; end
         default: dec.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mccu.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB state register plus Mealy
// output logic, so enables fire on the same edge the state advances.
module mccu
   import mccu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   mccu_if.master bus
);

   state_t     state_q;
   state_t     state_d;
   dec_t       dec;
   ctrl_t      ctl;
   logic [1:0] ex_srcb;

   mccu_decode u_decode (
      .op   (bus.op),
      .func (bus.func),
      .dec  (dec)
   );

   // R-type and branches take B from the register file, others from the immediate
   assign ex_srcb = (dec.rtype | dec.beq | dec.bne) ? 2'b00 : 2'b10;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IF;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ctl      = '0;
      ctl.aluc = ALUC_ADD;
      case (state_q)
         S_IF: begin
            ctl.alusrcb = 2'b01;
            ctl.wir     = bus.mem_rdy;
            ctl.wpc     = bus.mem_rdy;
            if (bus.mem_rdy) state_d = S_ID;
         end
         S_ID: begin
            ctl.alusrcb = 2'b11;
            ctl.sext    = 1'b1;
            state_d     = S_EXE;
            if (dec.j) begin
               ctl.wpc      = 1'b1;
               ctl.pcsource = 2'b11;
               state_d      = S_IF;
            end else if (dec.jal) begin
               ctl.wpc      = 1'b1;
               ctl.pcsource = 2'b11;
               ctl.wreg     = 1'b1;
               ctl.jal      = 1'b1;
               state_d      = S_IF;
            end else if (dec.jr) begin
               ctl.wpc      = 1'b1;
               ctl.pcsource = 2'b10;
               state_d      = S_IF;
            end else if (!dec.legal) begin
               ctl.illegal  = 1'b1;
               state_d      = S_IF;
            end
         end
         S_EXE: begin
            if (dec.beq) begin
               ctl.pcsource = 2'b01;
               ctl.wpc      = bus.z;
               state_d      = S_IF;
            end else if (dec.bne) begin
               ctl.pcsource = 2'b01;
               ctl.wpc      = ~bus.z;
               state_d      = S_IF;
            end else if (dec.lw | dec.sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ctl.iord = 1'b1;
            ctl.wmem = dec.sw & bus.mem_rdy;
            if (bus.mem_rdy) state_d = dec.lw ? S_WB : S_IF;
         end
         S_WB: begin
            ctl.wreg  = 1'b1;
            ctl.regrt = dec.itype | dec.lw;
            ctl.m2reg = dec.lw;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // ALU setup chosen in EXE stays stable until the result is written back
      if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
         ctl.alusrca = dec.shift;
         ctl.shift   = dec.shift;
         ctl.alusrcb = ex_srcb;
         ctl.sext    = dec.sext;
         ctl.aluc    = dec.aluc;
      end

      // Reset parks the selects at their fetch values with every write disabled
      if (!rst) begin
         ctl         = '0;
         ctl.alusrcb = 2'b01;
         ctl.aluc    = ALUC_ADD;
         state_d     = S_IF;
      end
   end

   assign bus.wpc      = ctl.wpc;
   assign bus.wir      = ctl.wir;
   assign bus.wmem     = ctl.wmem;
   assign bus.wreg     = ctl.wreg;
   assign bus.iord     = ctl.iord;
   assign bus.regrt    = ctl.regrt;
   assign bus.m2reg    = ctl.m2reg;
   assign bus.shift    = ctl.shift;
   assign bus.alusrca  = ctl.alusrca;
   assign bus.jal      = ctl.jal;
   assign bus.sext     = ctl.sext;
   assign bus.alusrcb  = ctl.alusrcb;
   assign bus.pcsource = ctl.pcsource;
   assign bus.aluc     = ctl.aluc;
   assign bus.illegal  = ctl.illegal;
   assign bus.state    = state_q;

endmodule
